// File: rtl/adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_pkg
// Shared constants for the pre/post-trigger capture engine:
//   - default sample width and capture depth
//   - FSM state codes
//   - trigger slope encodings
// -----------------------------------------------------------------------------
package adc_capture_pkg;

  localparam int ADC_W_DEF  = 14;
  localparam int ADDR_W_DEF = 10;

  // FSM state codes
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_POST  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // trig_slope_i encodings
  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/adc_capture_ram.sv
// -----------------------------------------------------------------------------
// adc_capture_ram
// Simple dual-port sample memory: one synchronous write port, one read port
// with a registered output.
// Ports:
//   clk      sample clock
//   rst_n    async active-low reset (clears only the read output register)
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, one cycle after raddr_i
// -----------------------------------------------------------------------------
module adc_capture_ram
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = ADC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are never reset so the memory maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register carries the reset so rd_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// -----------------------------------------------------------------------------
// adc_capture
// Pre/post-trigger capture engine. Keeps a circular sample history, arms after
// pre_depth samples, triggers on a level crossing (or force), records the
// remaining post-trigger samples and then freezes a window of 2^ADDR_W samples
// for readout, indexed from the oldest sample of the window.
// Ports:
//   clk, rst_n        sample clock, async active-low reset
//   adc_din_i         ADC sample (registered on input)
//   sample_en_i       qualifies adc_din_i
//   arm_i             start/restart a capture (highest priority)
//   force_i           immediate trigger while armed
//   trig_level_i      trigger threshold
//   trig_slope_i      0 rising, 1 falling
//   pre_depth_i       samples kept before the trigger sample
//   busy_o / done_o   capture in progress / window frozen
//   trig_addr_o       physical address of the trigger sample
//   rd_addr_i         logical read index (0 = oldest)
//   rd_data_o         sample at rd_addr_i, two cycles later
// -----------------------------------------------------------------------------
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int ADC_W  = ADC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADC_W-1:0]  adc_din_i,
  input  logic              sample_en_i,
  input  logic              arm_i,
  input  logic              force_i,
  input  logic [ADC_W-1:0]  trig_level_i,
  input  logic              trig_slope_i,
  input  logic [ADDR_W-1:0] pre_depth_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [ADC_W-1:0]  rd_data_o
);

  // Input sample register
  logic [ADC_W-1:0]  smp_q;
  logic              vld_q;

  // Control state
  logic [2:0]        state_q,      state_d;
  logic [ADDR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q,    pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q,   post_cnt_d;
  logic [ADDR_W-1:0] pre_depth_q,  pre_depth_d;
  logic [ADC_W-1:0]  level_q,      level_d;
  logic              slope_q,      slope_d;
  logic [ADC_W-1:0]  prev_q,       prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic              force_pend_q, force_pend_d;
  logic [ADDR_W-1:0] trig_addr_q,  trig_addr_d;
  logic [ADDR_W-1:0] rd_phys_q;

  logic              we;
  logic              level_hit;
  logic [ADDR_W-1:0] pre_cnt_inc;

  assign pre_cnt_inc = pre_cnt_q + ADDR_W'(1);

  // Crossing is judged between the previous and current qualified samples.
  always_comb begin
    level_hit = 1'b0;
    if (prev_valid_q) begin
      if (slope_q == SLOPE_FALL) begin
        level_hit = (prev_q > level_q) && (smp_q <= level_q);
      end else begin
        level_hit = (prev_q < level_q) && (smp_q >= level_q);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    pre_depth_d  = pre_depth_q;
    level_d      = level_q;
    slope_d      = slope_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    force_pend_d = force_pend_q;
    trig_addr_d  = trig_addr_q;
    we           = 1'b0;

    if (arm_i) begin
      pre_depth_d  = pre_depth_i;
      level_d      = trig_level_i;
      slope_d      = trig_slope_i;
      pre_cnt_d    = '0;
      post_cnt_d   = '0;
      prev_valid_d = 1'b0;
      force_pend_d = 1'b0;
      state_d      = ST_FILL;
    end else begin
      // Every qualified sample in an active state is stored and becomes prev.
      if (vld_q && (state_q == ST_FILL || state_q == ST_ARMED || state_q == ST_POST)) begin
        we           = 1'b1;
        wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
        prev_d       = smp_q;
        prev_valid_d = 1'b1;
      end

      case (state_q)
        ST_FILL: begin
          // A sample arriving once pre_cnt already matches is still kept;
          // it only extends history and keeps the window contiguous.
          if (pre_cnt_q == pre_depth_q) begin
            state_d = ST_ARMED;
          end else if (vld_q) begin
            pre_cnt_d = pre_cnt_inc;
            if (pre_cnt_inc == pre_depth_q) begin
              state_d = ST_ARMED;
            end
          end
        end

        ST_ARMED: begin
          // force is remembered until a qualified sample can carry it.
          force_pend_d = force_pend_q | force_i;
          if (vld_q && (level_hit || force_i || force_pend_q)) begin
            force_pend_d = 1'b0;
            trig_addr_d  = wr_ptr_q;
            // DEPTH-1-pre_depth in ADDR_W bits is just the complement.
            post_cnt_d   = ~pre_depth_q;
            state_d      = (pre_depth_q == {ADDR_W{1'b1}}) ? ST_DONE : ST_POST;
          end
        end

        ST_POST: begin
          if (vld_q) begin
            post_cnt_d = post_cnt_q - ADDR_W'(1);
            if (post_cnt_q == ADDR_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end

        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q        <= '0;
      vld_q        <= 1'b0;
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      pre_depth_q  <= '0;
      level_q      <= '0;
      slope_q      <= SLOPE_RISE;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      force_pend_q <= 1'b0;
      trig_addr_q  <= '0;
      rd_phys_q    <= '0;
    end else begin
      smp_q        <= adc_din_i;
      vld_q        <= sample_en_i;
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      pre_depth_q  <= pre_depth_d;
      level_q      <= level_d;
      slope_q      <= slope_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      force_pend_q <= force_pend_d;
      trig_addr_q  <= trig_addr_d;
      // Logical index 0 is the oldest sample: pre_depth before the trigger.
      rd_phys_q    <= trig_addr_q - pre_depth_q + rd_addr_i;
    end
  end

  adc_capture_ram #(
    .DATA_W (ADC_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (smp_q),
    .raddr_i (rd_phys_q),
    .rdata_o (rd_data_o)
  );

  assign busy_o      = (state_q == ST_FILL) || (state_q == ST_ARMED) || (state_q == ST_POST);
  assign done_o      = (state_q == ST_DONE);
  assign trig_addr_o = trig_addr_q;

endmodule

// File: doc/adc_capture.md
# adc_capture

Pre/post-trigger sample capture engine for the scope front end: takes parallel ADC samples on the system clock, keeps a circular history, detects a level/slope trigger or a forced trigger, freezes a window of 2^ADDR_W samples around it, and serves the window for readout. It is the receive-side counterpart of the DDS/DAC output path and shares its clock domain (PLL clkout0).

## Interface
- ADC_W, 14: sample width, unsigned straight binary
- ADDR_W, 10: capture depth DEPTH = 2^ADDR_W samples
- clk  in  1  system sample clock (clkout0)
- rst_n  in  1  reset, asynchronous, active-low
- adc_din  in  ADC_W  ADC sample, registered on input
- sample_en  in  1  qualifies adc_din this cycle
- arm  in  1  one-cycle pulse: start (or restart) a capture
- force  in  1  trigger immediately when ARMED
- trig_level  in  ADC_W  trigger threshold
- trig_slope  in  1  0 = rising, 1 = falling
- pre_depth  in  ADDR_W  samples kept before trigger sample
- busy  out  1  capture in progress
- done  out  1  window frozen and readable
- trig_addr  out  ADDR_W  physical address of trigger sample
- rd_addr  in  ADDR_W  logical read index, 0 = oldest sample of window
- rd_data  out  ADC_W  sample at rd_addr

## Operation
- States: IDLE, FILL, ARMED, POST, DONE. Reset -> IDLE.
- arm in any state: latch pre_depth and trig_level/trig_slope, clear counters, clear done, prev_valid=0, go FILL. arm has priority over every other event that cycle.
- FILL: each qualified sample written at wr_ptr, wr_ptr++ (wraps mod DEPTH), pre_cnt++. When pre_cnt reaches latched pre_depth go ARMED (pre_depth=0: FILL→ARMED after zero samples, i.e. on the cycle after arm). Triggers ignored in FILL.
- ARMED: keep writing. Trigger on a qualified sample if prev_valid and (rising: prev < level and cur >= level; falling: prev > level and cur <= level), or if force is high (force needs no sample_en, trigger sample is the next qualified sample). Trigger sample is written, its address stored in trig_addr, go POST with post_cnt = DEPTH-1-pre_depth.
- POST: each qualified sample written, post_cnt--. When post_cnt is 0 after a write (or immediately if it started at 0) go DONE.
- DONE: no writes, done=1, holds until arm.
- sample_en low: no write, no counter change, no trigger evaluation, prev held.
- prev updates on every qualified sample in FILL/ARMED/POST; prev_valid set on first.
- Read: physical = (trig_addr - pre_depth + rd_addr) mod DEPTH, unsigned wrap. Reads legal in any state; contents defined only in DONE.

## Timing
- Reset values: busy=0, done=0, trig_addr=0, rd_data=0, state IDLE, wr_ptr=0. RAM contents not reset.
- adc_din registered once: sample present at cycle N is written at N+1; trigger compare uses registered sample.
- busy=1 from cycle after arm until the cycle done rises; never both high.
- done rises the cycle after the last POST write.
- rd_data: 2-cycle latency from rd_addr (address map register + RAM output register), fully pipelined, one read per cycle.
- trig_addr valid from cycle after trigger write; stable until next arm.
- Reset mid-capture: immediate return to IDLE; next capture needs arm.

## Structure
- Package adc_capture_pkg: state enum, ADC_W/ADDR_W defaults, slope encodings.
- Sub-module capture_ram: simple dual-port, one write port, one registered read port, inferable as Gowin BSRAM.
- FSM, counters, trigger compare and read-address map stay in adc_capture.

## Test plan
- ADDR_W=4, pre_depth=4, rising, level=100, ramp 0,10,20…: trigger on sample 100; read 0..15 → 60,70,80,90,100,…,210; done after 11 post samples.
- Falling slope, level=50, descending ramp from 200 step 10: trigger sample 50; 40 (not 50) at pre=0 never triggers since prev must exceed level.
- force with flat input 7, pre_depth=0: trig sample read at rd_addr 0, all 16 reads = 7, done asserted 16 qualified samples after force.
- sample_en toggled 1/0 every cycle on rising ramp: captured window identical to gapless run; done latency doubles.
- Re-arm during POST: old capture aborted, done stays 0, new window correct; arm in DONE clears done next cycle.
- rst_n low mid-ARMED: busy/done/trig_addr/rd_data go 0 asynchronously; no write until next arm.
